vin_timing_conditioner: RTL

- Front-end conditioner for the 24-bit RGB capture path, running entirely in vin_clk.
- Sits directly upstream of the frame-buffer write controller and drives its vin_vs / vin_f / vin_de / vin_data / vin_width / vin_height inputs.
- Measures active timing per frame, crops to the frame-buffer plane size, and drops whole lines when the write FIFO reports almost-full, so the downstream pixel counter never loses line alignment.

---
 rtl/vin_pkg.sv | 25 ++
 rtl/vin_timing_conditioner_measure.sv | 98 +++++++++
 rtl/vin_timing_conditioner.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vin_pkg.sv
// ----------------------------------------------------------------------------
// vin_pkg : shared types and constants for the vin_clk capture front-end
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } drop_state_e;

  localparam int          c_max_width_dflt  = 1280;
  localparam int          c_max_height_dflt = 1024;
  localparam logic [7:0]  c_ramp_green      = 8'h80;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vin_timing_conditioner_measure.sv
// ----------------------------------------------------------------------------
// vin_timing_measure : pixel/line counters, per-frame size measurement,
//                      clamp to the frame-buffer plane and lock tracking
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vin_timing_measure
  import vin_pkg::*;
#(
  parameter int MAX_WIDTH     = c_max_width_dflt,
  parameter int MAX_HEIGHT    = c_max_height_dflt,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        vin_clk,
  input  logic        rst_n,
  input  logic        vs_rise,
  input  logic        line_start,
  input  logic        de,
  input  logic        de_fall,
  output logic [11:0] pix_idx,
  output logic [11:0] line_idx,
  output logic [11:0] width,
  output logic [11:0] height,
  output logic        locked
);

  localparam logic [11:0] c_max_w      = 12'(MAX_WIDTH);
  localparam logic [11:0] c_max_h      = 12'(MAX_HEIGHT);
  localparam logic [7:0]  c_lock_thr   = 8'(STABLE_FRAMES - 1);

  logic [11:0] r_pix_cnt, r_line_cnt, r_last_w;
  logic [11:0] r_prev_w, r_prev_h, r_width, r_height;
  logic [7:0]  r_stable_cnt;
  logic        r_in_line, r_locked;

  logic        w_line_done, w_meas_nz, w_meas_same;
  logic [11:0] w_meas_w, w_meas_h;
  logic [7:0]  w_stable_nxt;

  // A line that ends on the very cycle vsync rises still belongs to the old frame.
  assign w_line_done  = de_fall & r_in_line;
  assign w_meas_w     = w_line_done ? r_pix_cnt : r_last_w;
  assign w_meas_h     = w_line_done ? sat_inc12(r_line_cnt) : r_line_cnt;
  assign w_meas_nz    = (w_meas_w != 12'd0) && (w_meas_h != 12'd0);
  assign w_meas_same  = (w_meas_w == r_prev_w) && (w_meas_h == r_prev_h);
  assign w_stable_nxt = !w_meas_same ? 8'd0 :
                        (r_stable_cnt == 8'hFF) ? r_stable_cnt : r_stable_cnt + 8'd1;

  assign pix_idx  = line_start ? 12'd0 : r_pix_cnt;
  assign line_idx = vs_rise ? 12'd0 : r_line_cnt;
  assign width    = r_width;
  assign height   = r_height;
  assign locked   = r_locked;

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt  <= 12'd0;
      r_line_cnt <= 12'd0;
      r_last_w   <= 12'd0;
      r_in_line  <= 1'b0;
    end else begin
      if (line_start)  r_pix_cnt <= 12'd1;
      else if (de)     r_pix_cnt <= sat_inc12(r_pix_cnt);

      if (vs_rise)          r_line_cnt <= 12'd0;
      else if (w_line_done) r_line_cnt <= sat_inc12(r_line_cnt);

      if (w_line_done) r_last_w <= r_pix_cnt;

      if (line_start)              r_in_line <= 1'b1;
      else if (vs_rise || de_fall) r_in_line <= 1'b0;
    end
  end

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_w     <= 12'd0;
      r_prev_h     <= 12'd0;
      r_stable_cnt <= 8'd0;
      r_locked     <= 1'b0;
      r_width      <= c_max_w;
      r_height     <= c_max_h;
    end else if (vs_rise) begin
      r_prev_w     <= w_meas_w;
      r_prev_h     <= w_meas_h;
      r_stable_cnt <= w_stable_nxt;
      r_locked     <= (w_stable_nxt >= c_lock_thr) && w_meas_nz;
      if (w_meas_nz) begin
        r_width  <= (w_meas_w > c_max_w) ? c_max_w : w_meas_w;
        r_height <= (w_meas_h > c_max_h) ? c_max_h : w_meas_h;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vin_timing_conditioner.sv
// ----------------------------------------------------------------------------
// vin_timing_conditioner : 2-cycle conditioning pipe with crop, whole-line
//                          drop on FIFO almost-full and optional test pattern
//                          (VIN_TEST_PATTERN_EN adds the pattern_en input)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vin_timing_conditioner
  import vin_pkg::*;
#(
  parameter int MAX_WIDTH     = c_max_width_dflt,
  parameter int MAX_HEIGHT    = c_max_height_dflt,
  parameter int STABLE_FRAMES = 2,
  parameter int INTERLACE     = 1
) (
  input  logic        rst_n,
  input  logic        vin_clk,
`ifdef VIN_TEST_PATTERN_EN
  input  logic        pattern_en,
`endif
  input  logic        src_vs,
  input  logic        src_de,
  input  logic [23:0] src_data,
  input  logic        fifo_afull,
  output logic        vin_vs,
  output logic        vin_f,
  output logic        vin_de,
  output logic [23:0] vin_data,
  output logic [11:0] vin_width,
  output logic [11:0] vin_height,
  output logic        timing_locked,
  output logic [15:0] drop_cnt,
  output logic        overflow_err
);

  localparam logic [11:0] c_max_w = 12'(MAX_WIDTH);
  localparam logic [11:0] c_max_h = 12'(MAX_HEIGHT);

  logic        r_vs1, r_de1, r_de_ok1, r_afull_d, r_ovf;
  logic        r_vin_vs, r_vin_de;
  logic [23:0] r_data1, r_vin_data;
  logic [15:0] r_drop_cnt;
  drop_state_e r_state, w_line_state, w_state_nxt;

  logic        w_vs_rise, w_line_start, w_de_fall, w_afull_rise;
  logic        w_de_ok, w_vin_f;
  logic [11:0] w_pix_idx, w_line_idx;
  logic [23:0] w_data_in;

  assign w_vs_rise    = src_vs & ~r_vs1;
  assign w_line_start = src_de & ~r_de1;
  assign w_de_fall    = ~src_de & r_de1;
  assign w_afull_rise = fifo_afull & ~r_afull_d;

  vin_timing_measure #(
    .MAX_WIDTH     (MAX_WIDTH),
    .MAX_HEIGHT    (MAX_HEIGHT),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_measure (
    .vin_clk    (vin_clk),
    .rst_n      (rst_n),
    .vs_rise    (w_vs_rise),
    .line_start (w_line_start),
    .de         (src_de),
    .de_fall    (w_de_fall),
    .pix_idx    (w_pix_idx),
    .line_idx   (w_line_idx),
    .width      (vin_width),
    .height     (vin_height),
    .locked     (timing_locked)
  );

  // w_line_state is the state that governs the pixel on the input this cycle;
  // vsync abandons any open line before a coincident DE edge starts line 0.
  always_comb begin
    w_line_state = r_state;
    if (w_vs_rise)    w_line_state = ST_IDLE;
    if (w_line_start) w_line_state = fifo_afull ? ST_DROP : ST_PASS;
    w_state_nxt = w_de_fall ? ST_IDLE : w_line_state;
  end

  assign w_de_ok = src_de && (w_line_state == ST_PASS) &&
                   (w_pix_idx < c_max_w) && (w_line_idx < c_max_h);

`ifdef VIN_TEST_PATTERN_EN
  assign w_data_in = pattern_en ? {w_line_idx[7:0], c_ramp_green, w_pix_idx[7:0]} : src_data;
`else
  assign w_data_in = src_data;
`endif

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs1      <= 1'b0;
      r_de1      <= 1'b0;
      r_de_ok1   <= 1'b0;
      r_data1    <= 24'd0;
      r_vin_vs   <= 1'b0;
      r_vin_de   <= 1'b0;
      r_vin_data <= 24'd0;
      r_afull_d  <= 1'b0;
      r_state    <= ST_IDLE;
      r_drop_cnt <= 16'd0;
      r_ovf      <= 1'b0;
    end else begin
      r_vs1      <= src_vs;
      r_de1      <= src_de;
      r_de_ok1   <= w_de_ok;
      r_data1    <= w_data_in;
      r_vin_vs   <= r_vs1;
      r_vin_de   <= r_de_ok1;
      r_vin_data <= r_data1;
      r_afull_d  <= fifo_afull;
      r_state    <= w_state_nxt;
      if (w_line_start && fifo_afull && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
      // A line already passing is never truncated; late back-pressure is only flagged.
      if (w_afull_rise && src_de && !w_line_start && (w_line_state == ST_PASS))
        r_ovf <= 1'b1;
    end
  end

  generate
    if (INTERLACE != 0) begin : g_interlace
      logic r_field;
      always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n)         r_field <= 1'b0;
        else if (w_vs_rise) r_field <= ~r_field;
      end
      assign w_vin_f = r_field;
    end else begin : g_progressive
      assign w_vin_f = 1'b1;
    end
  endgenerate

  assign vin_vs       = r_vin_vs;
  assign vin_de       = r_vin_de;
  assign vin_data     = r_vin_data;
  assign vin_f        = w_vin_f;
  assign drop_cnt     = r_drop_cnt;
  assign overflow_err = r_ovf;

endmodule

`default_nettype wire
